// File: rtl/pc_fetch_seq.sv
// Instruction-fetch sequencer: PC register, credit-limited imem requests,
// and an in-order fetch buffer that is flushed on redirect.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] head_q, head_d;
    logic [CW-1:0] buf_q, buf_d;
    logic [CW-1:0] out_q, out_d;
    logic [31:0]   data_q [QDEPTH];
    logic [31:0]   data_d [QDEPTH];
    logic [31:0]   spc_q  [QDEPTH];
    logic [31:0]   spc_d  [QDEPTH];

    logic [CW:0]   occ;
    logic [CW:0]   fill_sum;
    logic [CW+1:0] alloc_sum;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] alloc_idx;
    logic          acc;
    logic          pop;
    logic          rsp_ok;

    // Slot order from head: buffered words, then allocated in-flight slots.
    assign occ       = {1'b0, buf_q} + {1'b0, out_q};
    assign fill_sum  = (CW+1)'(head_q) + (CW+1)'(buf_q);
    assign alloc_sum = (CW+2)'(fill_sum) + (CW+2)'(out_q);
    assign fill_idx  = fill_sum[AW-1:0];
    assign alloc_idx = alloc_sum[AW-1:0];

    assign imem_req_valid = (state_q == RUN) && (occ < (CW+1)'(QDEPTH))
                            && !redirect_valid;
    assign acc    = imem_req_valid && imem_req_ready;
    assign pop    = (buf_q != '0) && inst_ready;
    assign rsp_ok = imem_rsp_valid && (out_q != '0);

    assign pc_out        = pc_q;
    assign imem_req_addr = pc_q;
    assign inst_valid    = (buf_q != '0);
    assign inst_data     = data_q[head_q];
    assign inst_pc       = spc_q[head_q];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        buf_d   = buf_q;
        out_d   = out_q;
        data_d  = data_q;
        spc_d   = spc_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN, FLUSH: begin
                out_d = out_q + CW'(acc) - CW'(rsp_ok);
                if (acc) begin
                    pc_d = pc_q + PC_STEP;
                    spc_d[alloc_idx] = pc_q;
                end
                if (pop) begin
                    head_d = head_q + 1'b1;
                end
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    buf_d   = '0;
                    state_d = (out_d != '0) ? FLUSH : RUN;
                end else if (state_q == RUN) begin
                    if (rsp_ok) begin
                        data_d[fill_idx] = imem_rsp_data;
                    end
                    buf_d = buf_q + CW'(rsp_ok) - CW'(pop);
                end else if (out_d == '0) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            buf_q   <= '0;
            out_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_q[i] <= '0;
                spc_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            data_q  <= data_d;
            spc_q   <= spc_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing in flight breaks the memory protocol.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && out_q == '0));
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq with a 1-cycle-latency instruction memory
// model whose read data is the address xor a fixed key.
module tb_pc_fetch_seq;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_out;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    logic [31:0] pend[$];
    logic [31:0] reqlog[$];
    logic [31:0] ipclog[$];
    bit          hold;
    int          total = 0;
    int          bad = 0;

    pc_fetch_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc_out        (pc_out),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample 1ns later, log handshakes.
    task automatic cyc(input bit rrdy, input bit irdy, input bit rv,
                       input logic [31:0] rpc);
        @(negedge clk);
        imem_req_ready = rrdy;
        inst_ready     = irdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (!hold && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend.pop_front() ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            reqlog.push_back(imem_req_addr);
        end
        if (inst_valid && inst_ready) begin
            ipclog.push_back(inst_pc);
            chk("inst_data", inst_data, inst_pc ^ KEY);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        hold           = 1'b0;
        pend.delete();
        reqlog.delete();
        ipclog.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        bit seen10;
        int idx;

        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Streaming with everything ready.
        do_reset();
        repeat (12) cyc(1, 1, 0, 0);
        chk("t1_nreq", 32'(reqlog.size() >= 4), 32'd1);
        chk("t1_req0", reqlog[0], 32'h0);
        chk("t1_req1", reqlog[1], 32'h4);
        chk("t1_req2", reqlog[2], 32'h8);
        chk("t1_req3", reqlog[3], 32'hC);
        chk("t1_ninst", 32'(ipclog.size() >= 4), 32'd1);
        chk("t1_ipc0", ipclog[0], 32'h0);
        chk("t1_ipc1", ipclog[1], 32'h4);
        chk("t1_ipc2", ipclog[2], 32'h8);
        chk("t1_ipc3", ipclog[3], 32'hC);

        // Decode stalled: credits exhaust at two.
        do_reset();
        repeat (6) cyc(1, 0, 0, 0);
        chk("t2_nreq", 32'(reqlog.size()), 32'd2);
        chk("t2_req1", reqlog[1], 32'h4);
        chk("t2_full_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_inst_valid", 32'(inst_valid), 32'd1);
        chk("t2_inst_pc", inst_pc, 32'h0);
        cyc(1, 1, 0, 0);
        chk("t2_pop_no_credit", 32'(imem_req_valid), 32'd0);
        cyc(1, 1, 0, 0);
        chk("t2_credit_back", 32'(imem_req_valid), 32'd1);
        repeat (3) cyc(1, 1, 0, 0);
        chk("t2_req2", reqlog[2], 32'h8);
        chk("t2_ipc1", ipclog[1], 32'h4);

        // Redirect with two fetches in flight.
        do_reset();
        hold = 1'b1;
        repeat (4) cyc(1, 1, 0, 0);
        chk("t3_nreq", 32'(reqlog.size()), 32'd2);
        cyc(1, 1, 1, 32'h400);
        chk("t3_redir_prio", 32'(imem_req_valid), 32'd0);
        cyc(1, 1, 0, 0);
        chk("t3_pc", pc_out, 32'h400);
        chk("t3_flush_req", 32'(imem_req_valid), 32'd0);
        chk("t3_flush_inst", 32'(inst_valid), 32'd0);
        hold = 1'b0;
        repeat (7) cyc(1, 1, 0, 0);
        chk("t3_req2", reqlog[2], 32'h400);
        chk("t3_ipc0", ipclog[0], 32'h400);

        // Redirect while the 0x10 response is returning.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1, 1, 0, 0);
            if (reqlog.size() > 0 && reqlog[$] == 32'h10) found = 1'b1;
        end
        chk("t4_found10", 32'(found), 32'd1);
        idx = reqlog.size();
        cyc(1, 1, 1, 32'h400);
        repeat (8) cyc(1, 1, 0, 0);
        seen10 = 1'b0;
        foreach (ipclog[k]) if (ipclog[k] == 32'h10) seen10 = 1'b1;
        chk("t4_no_inst10", 32'(seen10), 32'd0);
        chk("t4_next_req", reqlog[idx], 32'h400);
        chk("t4_ipc_after", ipclog[ipclog.size() - 1] >= 32'h400 ? 32'd1 : 32'd0,
            32'd1);

        // Memory back-pressure holds the request stable.
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1, 1, 0, 0);
            if (reqlog.size() > 0 && reqlog[$] == 32'h8) found = 1'b1;
        end
        chk("t5_found8", 32'(found), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("t5_valid", 32'(imem_req_valid), 32'd1);
            chk("t5_addr", imem_req_addr, 32'hC);
            chk("t5_pc", pc_out, 32'hC);
        end
        idx = reqlog.size();
        cyc(1, 1, 0, 0);
        chk("t5_accept", reqlog[idx], 32'hC);

        // Asynchronous reset mid-cycle.
        do_reset();
        repeat (6) cyc(1, 1, 0, 0);
        chk("t6_running", 32'(pc_out != 32'h0), 32'd1);
        @(negedge clk);
        #2;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend.delete();
        #1;
        chk("t6_pc", pc_out, 32'h0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_inst_pc", inst_pc, 32'h0);
        chk("t6_inst_data", inst_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        reqlog.delete();
        ipclog.delete();
        repeat (4) cyc(1, 1, 0, 0);
        chk("t6_first_req", reqlog[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
